// File: rtl/packed_row_fifo.sv
// -----------------------------------------------------------------------------
// packed_row_fifo
//
// Purpose:
//   Captures completed packed rows from the upstream shift buffer into a small
//   show-ahead FIFO. The compute array drains rows through a valid/ready
//   handshake. The upstream buffer cannot be stalled. A push that arrives while
//   the FIFO is full, with no pop in the same cycle, is therefore dropped. Each
//   drop sets a sticky flag and increments a saturating counter.
//
// Ports:
//   clk          in   single clock, all state updates on posedge
//   rst_n        in   synchronous active-low reset
//   data_i       in   packed row (buffer_SIZE words of buffer_WIDTH bits)
//   data_valid_i in   one-cycle push strobe aligned with data_i
//   data_o       out  head row, 0 when empty
//   valid_o      out  FIFO non-empty
//   ready_i      in   consumer accepts the head row this cycle
//   count_o      out  occupancy, 0..FIFO_DEPTH
//   overflow_o   out  sticky, set once any push has been dropped
//   drop_cnt_o   out  number of dropped pushes, saturates at 255
// -----------------------------------------------------------------------------
module packed_row_fifo #(
    parameter int buffer_SIZE  = 8,
    parameter int buffer_WIDTH = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [buffer_WIDTH*buffer_SIZE-1:0]  data_i,
    input  logic                                 data_valid_i,
    output logic [buffer_WIDTH*buffer_SIZE-1:0]  data_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [$clog2(FIFO_DEPTH):0]          count_o,
    output logic                                 overflow_o,
    output logic [7:0]                           drop_cnt_o
);

    localparam int ROW_W = buffer_WIDTH * buffer_SIZE;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [ROW_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [7:0]       drop_cnt;

    logic pop;
    logic push_ok;
    logic drop;

    // A full FIFO still accepts a push when the head is popped in the same
    // cycle. The write slot is the one being freed, because wr_ptr == rd_ptr
    // when the FIFO is full.
    always_comb begin
        pop     = (count != '0) && ready_i;
        push_ok = data_valid_i && ((count < FULL_COUNT) || pop);
        drop    = data_valid_i && !push_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: storage is cleared on reset, so no stale row can ever be
            // observed. Non-blocking assignments keep every register update
            // in this block order-independent.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // Outputs come only from registers. There is no path from data_i or
    // data_valid_i to any output.
    assign valid_o    = (count != '0);
    assign data_o     = (count != '0) ? mem[rd_ptr] : '0;
    assign count_o    = count;
    assign overflow_o = overflow;
    assign drop_cnt_o = drop_cnt;

endmodule
